// File: rtl/tl_mem_arbiter.sv
// Two-master round-robin arbiter for the shared cacheline memory port.
// Tracks per-master outstanding requests and routes D beats by source MSB.
module tl_mem_arbiter #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int SRC_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 m_a_valid,
  output logic [1:0]                 m_a_ready,
  input  logic [1:0][2:0]            m_a_opcode,
  input  logic [1:0][ADDR_WIDTH-1:0] m_a_address,
  input  logic [1:0][DATA_WIDTH-1:0] m_a_data,
  input  logic [1:0][SRC_WIDTH-1:0]  m_a_source,
  output logic                       s_a_valid,
  input  logic                       s_a_ready,
  output logic [2:0]                 s_a_opcode,
  output logic [ADDR_WIDTH-1:0]      s_a_address,
  output logic [DATA_WIDTH-1:0]      s_a_data,
  output logic [SRC_WIDTH:0]         s_a_source,
  input  logic                       s_d_valid,
  output logic                       s_d_ready,
  input  logic [2:0]                 s_d_opcode,
  input  logic [DATA_WIDTH-1:0]      s_d_data,
  input  logic [SRC_WIDTH:0]         s_d_source,
  output logic [1:0]                 m_d_valid,
  input  logic [1:0]                 m_d_ready,
  output logic [2:0]                 m_d_opcode,
  output logic [DATA_WIDTH-1:0]      m_d_data,
  output logic [SRC_WIDTH-1:0]       m_d_source,
  output logic                       err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);

  logic          rr_ptr;
  logic          lock_q;
  logic          gnt_q;
  logic          err_q;
  logic [CW-1:0] cnt [2];

  logic [1:0] elig;
  logic       gv;
  logic       g;
  logic       id;
  logic       a_hs;
  logic       d_hs;
  logic [1:0] inc;
  logic [1:0] dec;

  assign elig[0] = m_a_valid[0] && (cnt[0] < MAXC);
  assign elig[1] = m_a_valid[1] && (cnt[1] < MAXC);

  // A locked grant ignores eligibility so a stalled request is never dropped
  always_comb begin
    gv = 1'b0;
    g  = rr_ptr;
    if (lock_q) begin
      gv = 1'b1;
      g  = gnt_q;
    end else if (elig[rr_ptr]) begin
      gv = 1'b1;
      g  = rr_ptr;
    end else if (elig[~rr_ptr]) begin
      gv = 1'b1;
      g  = ~rr_ptr;
    end
  end

  assign s_a_valid   = gv && !rst;
  assign s_a_opcode  = m_a_opcode[g];
  assign s_a_address = m_a_address[g];
  assign s_a_data    = m_a_data[g];
  assign s_a_source  = {g, m_a_source[g]};

  always_comb begin
    m_a_ready = '0;
    if (s_a_valid) m_a_ready[g] = s_a_ready;
  end

  assign id         = s_d_source[SRC_WIDTH];
  assign s_d_ready  = !rst && m_d_ready[id];
  assign m_d_opcode = s_d_opcode;
  assign m_d_data   = s_d_data;
  assign m_d_source = s_d_source[SRC_WIDTH-1:0];

  always_comb begin
    m_d_valid = '0;
    if (!rst) m_d_valid[id] = s_d_valid;
  end

  assign a_hs  = s_a_valid && s_a_ready;
  assign d_hs  = s_d_valid && s_d_ready;
  assign err_o = err_q && !rst;

  always_comb begin
    inc = '0;
    dec = '0;
    if (a_hs) inc[g] = 1'b1;
    if (d_hs) dec[id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      lock_q <= 1'b0;
      gnt_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      if (a_hs) begin
        rr_ptr <= ~g;
        lock_q <= 1'b0;
      end else if (gv) begin
        lock_q <= 1'b1;
        gnt_q  <= g;
      end
      if (d_hs && cnt[id] == '0) err_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Directed bench for tl_mem_arbiter: vector table plus lock and
// full-counter sequences.
module tb_tl_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         m_a_valid;
  logic [1:0]         m_a_ready;
  logic [1:0][2:0]    m_a_opcode;
  logic [1:0][AW-1:0] m_a_address;
  logic [1:0][DW-1:0] m_a_data;
  logic [1:0][SW-1:0] m_a_source;
  logic               s_a_valid;
  logic               s_a_ready;
  logic [2:0]         s_a_opcode;
  logic [AW-1:0]      s_a_address;
  logic [DW-1:0]      s_a_data;
  logic [SW:0]        s_a_source;
  logic               s_d_valid;
  logic               s_d_ready;
  logic [2:0]         s_d_opcode;
  logic [DW-1:0]      s_d_data;
  logic [SW:0]        s_d_source;
  logic [1:0]         m_d_valid;
  logic [1:0]         m_d_ready;
  logic [2:0]         m_d_opcode;
  logic [DW-1:0]      m_d_data;
  logic [SW-1:0]      m_d_source;
  logic               err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_a_opcode(m_a_opcode), .m_a_address(m_a_address),
    .m_a_data(m_a_data), .m_a_source(m_a_source),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_a_opcode(s_a_opcode), .s_a_address(s_a_address),
    .s_a_data(s_a_data), .s_a_source(s_a_source),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .s_d_opcode(s_d_opcode), .s_d_data(s_d_data),
    .s_d_source(s_d_source),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .m_d_opcode(m_d_opcode), .m_d_data(m_d_data),
    .m_d_source(m_d_source), .err_o(err_o)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] av;
    logic       ar;
    logic       dv;
    logic [4:0] ds;
    logic [1:0] dr;
    logic       sv;
    logic [1:0] mar;
    logic [4:0] src;
    logic [1:0] mdv;
    logic       sdr;
    logic       err;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] av,
                       input logic ar, input logic dv,
                       input logic [4:0] ds, input logic [1:0] dr);
    @(negedge clk);
    rst        = r;
    m_a_valid  = av;
    s_a_ready  = ar;
    s_d_valid  = dv;
    s_d_source = ds;
    m_d_ready  = dr;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
  endtask

  // Grant checks: valid, per-master ready, and tagged source
  task automatic chk_a(input string nm, input logic sv,
                       input logic [1:0] mar, input logic [4:0] src);
    check({nm, "_sv"}, DW'(s_a_valid), DW'(sv));
    check({nm, "_rdy"}, DW'(m_a_ready), DW'(mar));
    if (sv) check({nm, "_src"}, DW'(s_a_source), DW'(src));
  endtask

  initial begin
    m_a_opcode     = '0;
    m_a_opcode[0]  = 3'd4;
    m_a_opcode[1]  = 3'd1;
    m_a_address[0] = 64'hA000_0000_0000_1040;
    m_a_address[1] = 64'hB000_0000_0000_2080;
    m_a_data[0]    = {16{32'h0D0D_0001}};
    m_a_data[1]    = {16{32'h1D1D_0002}};
    m_a_source[0]  = 4'h2;
    m_a_source[1]  = 4'h7;
    s_d_opcode     = 3'd1;
    s_d_data       = {16{32'hFEED_BEEF}};
    rst = 1'b1; m_a_valid = '0; s_a_ready = 1'b0;
    s_d_valid = 1'b0; s_d_source = '0; m_d_ready = '0;

    tbl[0]  = '{1'b1, 2'b11, 1'b1, 1'b1, 5'h10, 2'b11,
                1'b0, 2'b00, 5'h00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00,
                1'b1, 2'b01, 5'h02, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00,
                1'b1, 2'b10, 5'h17, 2'b00, 1'b0, 1'b0};
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[2];
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 5'h03, 2'b01,
                1'b0, 2'b00, 5'h00, 2'b01, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b1, 5'h13, 2'b01,
                1'b0, 2'b00, 5'h00, 2'b10, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 5'h13, 2'b11,
                1'b0, 2'b00, 5'h00, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 1'b1, 5'h03, 2'b01,
                1'b1, 2'b01, 5'h02, 2'b01, 1'b1, 1'b0};
    tbl[9]  = tbl[5];
    tbl[10] = tbl[5];
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 5'h00, 2'b00,
                1'b0, 2'b00, 5'h00, 2'b00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b1, 5'h13, 2'b10,
                1'b0, 2'b00, 5'h00, 2'b10, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 2'b00, 1'b0, 1'b0, 5'h00, 2'b00,
                1'b0, 2'b00, 5'h00, 2'b00, 1'b0, 1'b0};
    tbl[14] = tbl[1];

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ar,
            tbl[i].dv, tbl[i].ds, tbl[i].dr);
      chk_a($sformatf("v%0d", i), tbl[i].sv, tbl[i].mar, tbl[i].src);
      check($sformatf("v%0d_mdv", i), DW'(m_d_valid), DW'(tbl[i].mdv));
      check($sformatf("v%0d_sdr", i), DW'(s_d_ready), DW'(tbl[i].sdr));
      check($sformatf("v%0d_mds", i), DW'(m_d_source), DW'(tbl[i].ds[3:0]));
      check($sformatf("v%0d_err", i), DW'(err_o), DW'(tbl[i].err));
    end
    check("d_data", m_d_data, {16{32'hFEED_BEEF}});

    // Lock: master 0 stalls while rr_ptr points at master 1
    do_reset();
    drive(1'b0, 2'b01, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("lk0", 1'b1, 2'b01, 5'h02);
    drive(1'b0, 2'b01, 1'b0, 1'b0, 5'h00, 2'b00);
    chk_a("lk1", 1'b1, 2'b00, 5'h02);
    drive(1'b0, 2'b11, 1'b0, 1'b0, 5'h00, 2'b00);
    chk_a("lk2", 1'b1, 2'b00, 5'h02);
    drive(1'b0, 2'b11, 1'b0, 1'b0, 5'h00, 2'b00);
    chk_a("lk3", 1'b1, 2'b00, 5'h02);
    drive(1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("lk4", 1'b1, 2'b01, 5'h02);
    check("lk4_addr", DW'(s_a_address), DW'(64'hA000_0000_0000_1040));
    check("lk4_op", DW'(s_a_opcode), DW'(3'd4));
    check("lk4_data", s_a_data, {16{32'h0D0D_0001}});
    drive(1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("lk5", 1'b1, 2'b10, 5'h17);
    check("lk5_addr", DW'(s_a_address), DW'(64'hB000_0000_0000_2080));

    // Full: master 1 fills its four slots, then master 0 takes over
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 2'b00);
      chk_a($sformatf("fl%0d", i), 1'b1, 2'b10, 5'h17);
    end
    drive(1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("fl4", 1'b1, 2'b01, 5'h02);
    drive(1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("fl5", 1'b1, 2'b01, 5'h02);
    drive(1'b0, 2'b10, 1'b0, 1'b1, 5'h17, 2'b10);
    chk_a("fl6", 1'b0, 2'b00, 5'h00);
    check("fl6_mdv", DW'(m_d_valid), DW'(2'b10));
    check("fl6_sdr", DW'(s_d_ready), DW'(1'b1));
    drive(1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 2'b00);
    chk_a("fl7", 1'b1, 2'b10, 5'h17);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'h00, 2'b00);
    check("fl8_err", DW'(err_o), DW'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_mem_arbiter.md
Name: tl_mem_arbiter

Overview:
- Shares the core's single cacheline-wide memory port between two requesters: master 0 = instruction bus, master 1 = data bus.
- Sits between the fetch/LSU bus masters inside aura_core and the downstream memory slave.
- Arbitrates the request (A) channel round-robin and tracks outstanding transactions per master.
- Routes response (D) channel beats back to the issuing master by a master-id bit prepended to the source tag.

Parameters:
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 512, cacheline data width (CACHELINE_SIZE bits).
- SRC_WIDTH, 4, per-master source tag width.
- MAX_OUTSTANDING, 4, maximum in-flight requests per master; minimum 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- m_a_valid  in  2  per-master request valid.
- m_a_ready  out  2  per-master request ready.
- m_a_opcode  in  2x3  per-master opcode.
- m_a_address  in  2xADDR_WIDTH  per-master address.
- m_a_data  in  2xDATA_WIDTH  per-master write data.
- m_a_source  in  2xSRC_WIDTH  per-master source tag.
- s_a_valid  out  1  slave request valid.
- s_a_ready  in  1  slave request ready.
- s_a_opcode  out  3  granted opcode.
- s_a_address  out  ADDR_WIDTH  granted address.
- s_a_data  out  DATA_WIDTH  granted data.
- s_a_source  out  SRC_WIDTH+1  {master_id, m_a_source}.
- s_d_valid  in  1  slave response valid.
- s_d_ready  out  1  slave response ready.
- s_d_opcode  in  3  response opcode.
- s_d_data  in  DATA_WIDTH  response data.
- s_d_source  in  SRC_WIDTH+1  echoed source tag.
- m_d_valid  out  2  per-master response valid.
- m_d_ready  in  2  per-master response ready.
- m_d_opcode  out  3  response opcode (broadcast to both masters).
- m_d_data  out  DATA_WIDTH  response data (broadcast to both masters).
- m_d_source  out  SRC_WIDTH  s_d_source[SRC_WIDTH-1:0].
- err_o  out  1  sticky protocol error.

Behaviour:
- State registers: rr_ptr (1b), lock_q (1b), gnt_q (1b), cnt[2] (clog2(MAX_OUTSTANDING+1) bits), err_q.
- Reset: all state registers clear to 0. While rst=1, s_a_valid, m_a_ready, s_d_ready, m_d_valid and err_o are forced to 0.
- Eligibility: elig[i] = m_a_valid[i] && cnt[i] < MAX_OUTSTANDING.
- Arbitration, zero latency:
  - If lock_q=0: grant = rr_ptr when elig[rr_ptr], else the other master if it is eligible.
  - If lock_q=1: grant = gnt_q.
- A-channel outputs: s_a_valid = a grant exists. Payload is muxed from the granted master. m_a_ready[g] = s_a_ready for the granted master; the other master's ready is 0.
- A handshake (s_a_valid && s_a_ready):
  - cnt[g] increments.
  - rr_ptr <= ~g.
  - lock_q <= 0.
- Grant with s_a_ready=0: lock_q <= 1 and gnt_q <= g. The grant holds until the handshake completes. Masters must hold valid and payload stable; the arbiter does not re-arbitrate while locked.
- D-channel routing:
  - id = s_d_source[SRC_WIDTH].
  - m_d_valid[id] = s_d_valid; m_d_valid[~id] = 0.
  - s_d_ready = m_d_ready[id].
  - D passthrough is purely combinational; the arbiter adds no response buffering.
  - D handshake decrements cnt[id].
- Same-cycle A and D handshake on the same master: cnt is unchanged (net 0).
- Full condition: a master at cnt=MAX_OUTSTANDING is ineligible, so the other master may be granted. A locked grant remains valid even after the counter reaches the cap.
- D handshake when cnt[id]==0:
  - err_q <= 1 (sticky until reset).
  - The counter saturates at 0 (no wrap).
  - The beat is still forwarded.
- Back-to-back: one grant per cycle. With both masters continuously eligible and s_a_ready=1, grants alternate 0,1,0,1 starting at 0 after reset.
- Reset mid-transaction: lock, grant and counters clear. In-flight slave responses after reset count as errors only if they arrive after rst deasserts. The system must reset the slave together with the arbiter.

Test Plan:
- Both masters valid, s_a_ready=1 for 4 cycles after reset -> grants 0,1,0,1; s_a_source MSB = 0,1,0,1; cnt = {2,2}.
- Master 0 valid, s_a_ready=0 for 3 cycles, master 1 raises valid in cycle 2 -> grant stays 0 throughout; m_a_ready[1]=0; handshake on cycle 4 transfers master 0's address; master 1 is granted next cycle.
- Master 1 issues 4 requests with no responses (MAX_OUTSTANDING=4) -> 5th request is stalled with m_a_ready[1]=0 while master 0 continues to be granted; one D beat with source MSB=1 -> master 1 is granted the next cycle.
- s_d_valid with s_d_source=5'b1_0011, m_d_ready=2'b01 -> m_d_valid=2'b10, s_d_ready=0, m_d_source=4'h3; when m_d_ready[1]=1 -> handshake completes and cnt[1] decrements.
- Same-cycle A handshake on master 0 and D handshake for master 0 with cnt[0]=2 -> cnt[0] remains 2.
- D beat for master 0 with cnt[0]=0 -> err_o=1 next cycle and stays 1 until rst; cnt[0] stays 0.
